mux_rr_arbiter: RTL

- Round-robin arbiter and sequencer that shares the parametric multiplexer between 2**N_SEL requesters.
- Grants one requester at a time and drives the mux selector from the grant.
- Holds the grant for a multi-word burst that the requester closes with a last flag.
- Places accepted words in a one-entry registered output stage with valid/ready handshake toward the downstream consumer.

---
 rtl/mux_arb_pkg.sv | 10 +
 rtl/mux_pkg.sv | 9 +
 rtl/rr_pick.sv | 29 ++
 rtl/mux_rr_arbiter.sv | 116 +++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Arbiter-level types layered on top of the shared multiplexer package.
package mux_arb_pkg;
  import mux_pkg::*;

  localparam int N_REQ       = 2**N_SEL;
  localparam int TIMEOUT_DEF = 16;

  typedef logic [N_REQ-1:0] req_vec_t;
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} arb_state_e;
endpackage

// File: rtl/mux_pkg.sv
// Shared multiplexer types: data width, selector width and the requester data bus.
package mux_pkg;
  localparam int W_DW  = 6;
  localparam int N_SEL = 2;

  typedef logic [W_DW-1:0]              dtwidth_t;
  typedef logic [N_SEL-1:0]             selectr_t;
  typedef dtwidth_t [2**N_SEL-1:0]      in_bus_t;
endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: rotate requests past the pointer, find the first set bit, rotate back.
module rr_pick
  import mux_pkg::*;
  import mux_arb_pkg::*;
(
  input  req_vec_t req,
  input  selectr_t ptr,
  output selectr_t winner,
  output logic     any
);

  req_vec_t         rot;
  selectr_t         first;
  logic [N_SEL:0]   shift;

  always_comb begin
    shift = {1'b0, ptr} + (N_SEL+1)'(1);
    // rot[j] holds req[(ptr+1+j) mod N_REQ]
    rot   = req_vec_t'({req, req} >> shift);
    first = '0;
    for (int i = N_REQ-1; i >= 0; i--) begin
      if (rot[i]) first = selectr_t'(i);
    end
    winner = first + ptr + selectr_t'(1);
  end

  assign any = |req;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin burst arbiter driving the shared mux selector, with a one-entry output stage.
// Optional idle-owner release with sticky timeout_o when MUX_ARB_TIMEOUT_EN is defined.
module mux_rr_arbiter
  import mux_pkg::*;
  import mux_arb_pkg::*;
`ifdef MUX_ARB_TIMEOUT_EN
#(
  parameter int TIMEOUT = TIMEOUT_DEF
)
`endif
(
  input  logic     clk,
  input  logic     rst,
  input  req_vec_t req_i,
  input  req_vec_t last_i,
  input  in_bus_t  data_i,
  output req_vec_t ack_o,
  output selectr_t sel_o,
  output logic     busy_o,
  output dtwidth_t data_o,
  output logic     valid_o,
  input  logic     ready_i
`ifdef MUX_ARB_TIMEOUT_EN
  ,
  output logic     timeout_o
`endif
);

  arb_state_e state_q, state_d;
  selectr_t   ptr_q, ptr_d, sel_d, winner;
  logic       any, xfer, timeout_fire;

  rr_pick u_pick (
    .req    (req_i),
    .ptr    (ptr_q),
    .winner (winner),
    .any    (any)
  );

  assign busy_o = (state_q == GRANT);
  assign xfer   = busy_o && req_i[sel_o] && (!valid_o || ready_i);
  assign ack_o  = xfer ? (req_vec_t'(1) << sel_o) : '0;

`ifdef MUX_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT+1);

  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;

  always_comb begin
    timeout_fire = busy_o && !req_i[sel_o] && (idle_cnt_q == CNT_W'(TIMEOUT-1));
    idle_cnt_d   = idle_cnt_q;
    if (!busy_o || xfer)     idle_cnt_d = '0;
    else if (!req_i[sel_o])  idle_cnt_d = idle_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_cnt_q <= '0;
      timeout_o  <= 1'b0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
      timeout_o  <= timeout_o | timeout_fire;
    end
  end
`else
  assign timeout_fire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_o;
    case (state_q)
      IDLE: begin
        if (any) begin
          state_d = GRANT;
          sel_d   = winner;
        end
      end
      GRANT: begin
        // The owner keeps the grant until its last word or a forced release.
        if ((xfer && last_i[sel_o]) || timeout_fire) begin
          state_d = IDLE;
          ptr_d   = sel_o;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= selectr_t'(N_REQ-1);
      sel_o   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_o   <= sel_d;
    end
  end

  // output stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_o  <= '0;
      valid_o <= 1'b0;
    end else if (xfer) begin
      data_o  <= data_i[sel_o];
      valid_o <= 1'b1;
    end else if (ready_i && valid_o) begin
      valid_o <= 1'b0;
    end
  end

endmodule
